// File: rtl/su_operand_conditioner.sv
`default_nettype none
// ============================================================================
// su_operand_conditioner : two-operand sign/magnitude front-end, elastic pipe
// Revision 1.0 : initial release
// ============================================================================
module su_operand_conditioner #(
  parameter int DATA_WIDTH  = 8,
  parameter int PIPE_STAGES = 1
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] A_mag,
  output logic [DATA_WIDTH-1:0] B_mag,
  output logic                  prod_neg,
  output logic                  A_minneg,
  output logic                  B_minneg
);

  localparam int c_pw = 2 * DATA_WIDTH + 3;

  logic                  w_sa;
  logic                  w_sb;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic                  w_a_minneg;
  logic                  w_b_minneg;
  logic                  w_prod_neg;
  logic [c_pw-1:0]       w_payload;
  logic [c_pw-1:0]       w_out;
  logic                  w_next_ready;

  logic                  r_v1;
  logic [c_pw-1:0]       r_p1;

  always_comb begin
    w_sa       = signed_mode & A[DATA_WIDTH-1];
    w_sb       = signed_mode & B[DATA_WIDTH-1];
    w_a_mag    = w_sa ? (~A + DATA_WIDTH'(1)) : A;
    w_b_mag    = w_sb ? (~B + DATA_WIDTH'(1)) : B;
    w_a_minneg = w_sa & ~(|A[DATA_WIDTH-2:0]);
    w_b_minneg = w_sb & ~(|B[DATA_WIDTH-2:0]);
    // A magnitude is zero exactly when the operand is zero, so no negative zero
    w_prod_neg = (w_sa ^ w_sb) & (|A) & (|B);
    w_payload  = {w_a_mag, w_b_mag, w_prod_neg, w_a_minneg, w_b_minneg};
  end

  assign in_ready = ~r_v1 | w_next_ready;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_p1 <= '0;
    end else if (in_ready) begin
      r_v1 <= in_valid;
      if (in_valid) r_p1 <= w_payload;
    end
  end

  generate
    if (PIPE_STAGES == 2) begin : g_two_stage
      logic            r_v2;
      logic [c_pw-1:0] r_p2;

      // Stage 2 fills whenever empty, so bubbles collapse under backpressure
      assign w_next_ready = ~r_v2 | out_ready;

      always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
          r_v2 <= 1'b0;
          r_p2 <= '0;
        end else if (w_next_ready) begin
          r_v2 <= r_v1;
          if (r_v1) r_p2 <= r_p1;
        end
      end

      assign out_valid = r_v2;
      assign w_out     = r_p2;
    end else begin : g_one_stage
      assign w_next_ready = out_ready;
      assign out_valid    = r_v1;
      assign w_out        = r_p1;
    end
  endgenerate

  assign {A_mag, B_mag, prod_neg, A_minneg, B_minneg} = w_out;

endmodule
`default_nettype wire

// File: tb/tb_su_operand_conditioner.sv
`default_nettype none
// ============================================================================
// tb_su_operand_conditioner : checks PIPE_STAGES=1 and =2 instances side by side
// Revision 1.0 : initial release
// ============================================================================
module tb_su_operand_conditioner;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    int         t;
  } item_t;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       signed_mode;

  logic       irdy [2];
  logic       ovld [2];
  logic [7:0] amag [2];
  logic [7:0] bmag [2];
  logic       pn   [2];
  logic       amn  [2];
  logic       bmn  [2];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc_n   = 0;
  int    pops [2];
  item_t q0 [$];
  item_t q1 [$];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    su_operand_conditioner #(.DATA_WIDTH(8), .PIPE_STAGES(g + 1)) u_dut (
      .Clk(Clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(irdy[g]),
      .A(A), .B(B), .signed_mode(signed_mode), .out_valid(ovld[g]),
      .out_ready(out_ready), .A_mag(amag[g]), .B_mag(bmag[g]),
      .prod_neg(pn[g]), .A_minneg(amn[g]), .B_minneg(bmn[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: magnitude by plain arithmetic, sign rules straight from the definition
  function automatic logic [18:0] exp_of(input logic [7:0] a, input logic [7:0] b, input logic m);
    int  va, vb;
    bit  na, nb;
    logic [7:0] ma, mb;
    va = (m && a >= 128) ? int'(a) - 256 : int'(a);
    vb = (m && b >= 128) ? int'(b) - 256 : int'(b);
    na = va < 0;
    nb = vb < 0;
    ma = 8'(na ? -va : va);
    mb = 8'(nb ? -vb : vb);
    return {ma, mb, (va * vb) < 0, va == -128, vb == -128};
  endfunction

  function automatic logic [18:0] dut_out(input int k);
    return {amag[k], bmag[k], pn[k], amn[k], bmn[k]};
  endfunction

  // Scoreboard: per-instance FIFO of accepted pairs with their acceptance cycle
  always @(posedge Clk) begin
    item_t it, dropped;
    if (!reset_n) begin
      q0.delete();
      q1.delete();
    end else begin
      it = '{a: A, b: B, m: signed_mode, t: cyc_n};
      if (ovld[0] && out_ready) begin
        if (q0.size() > 0) dropped = q0.pop_front();
        pops[0]++;
      end
      if (ovld[1] && out_ready) begin
        if (q1.size() > 0) dropped = q1.pop_front();
        pops[1]++;
      end
      if (in_valid && irdy[0]) q0.push_back(it);
      if (in_valid && irdy[1]) q1.push_back(it);
    end
    cyc_n++;
  end

  always @(negedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      int    cnt;
      item_t hd;
      bit    exp_v;
      if (!reset_n) begin
        chk($sformatf("rst_valid%0d", k), 32'(ovld[k]), 32'd0);
        chk($sformatf("rst_data%0d", k), 32'(dut_out(k)), 32'd0);
        chk($sformatf("rst_ready%0d", k), 32'(irdy[k]), 32'd1);
      end else begin
        cnt = (k == 0) ? q0.size() : q1.size();
        if (cnt > 0) hd = (k == 0) ? q0[0] : q1[0];
        exp_v = (cnt > 0) && ((cyc_n - hd.t) >= (k + 1));
        chk($sformatf("in_ready%0d", k), 32'(irdy[k]), 32'((cnt < k + 1) || out_ready));
        chk($sformatf("out_valid%0d", k), 32'(ovld[k]), 32'(exp_v));
        if (exp_v && ovld[k])
          chk($sformatf("payload%0d", k), 32'(dut_out(k)), 32'(exp_of(hd.a, hd.b, hd.m)));
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h00;
      2:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic drive_rand();
    A           = rnd8();
    B           = rnd8();
    signed_mode = 1'($urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
  endtask

  // Single pair into empty pipes; pinned literal result at each latency
  task automatic directed(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic m, input logic [18:0] exp);
    drain();
    A = a; B = b; signed_mode = m; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge Clk);
    chk({nm, "_v_p1"}, 32'(ovld[0]), 32'd1);
    chk({nm, "_p1"}, 32'(dut_out(0)), 32'(exp));
    chk({nm, "_v0_p2"}, 32'(ovld[1]), 32'd0);
    step();
    @(negedge Clk);
    chk({nm, "_v_p2"}, 32'(ovld[1]), 32'd1);
    chk({nm, "_p2"}, 32'(dut_out(1)), 32'(exp));
  endtask

  initial begin
    pops[0] = 0; pops[1] = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; signed_mode = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    directed("signed",   8'hFB, 8'h03, 1'b1, {8'h05, 8'h03, 1'b1, 1'b0, 1'b0});
    directed("unsigned", 8'hFB, 8'h00, 1'b0, {8'hFB, 8'h00, 1'b0, 1'b0, 1'b0});
    directed("minneg_z", 8'h80, 8'h00, 1'b1, {8'h80, 8'h00, 1'b0, 1'b1, 1'b0});
    directed("minneg2",  8'h80, 8'h80, 1'b1, {8'h80, 8'h80, 1'b0, 1'b1, 1'b1});
    directed("mixed",    8'h7F, 8'hFF, 1'b1, {8'h7F, 8'h01, 1'b1, 1'b0, 1'b0});

    // Reset with pairs in flight and the output stalled
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    drive_rand(); step();
    drive_rand(); step();
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_rst_valid%0d", k), 32'(ovld[k]), 32'd0);
      chk($sformatf("async_rst_data%0d", k), 32'(dut_out(k)), 32'd0);
      chk($sformatf("async_rst_ready%0d", k), 32'(irdy[k]), 32'd1);
    end
    in_valid = 1'b0;
    step(); step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready0", 32'(irdy[0]), 32'd1);
    chk("post_rst_ready1", 32'(irdy[1]), 32'd1);
    out_ready = 1'b1;
    step();

    // Backpressure pattern 1,0,0,1 while streaming
    for (int i = 0; i < 14; i++) begin
      in_valid  = 1'b1;
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      drive_rand();
      step();
    end
    drain();

    // Full rate: 16 pairs back to back
    pops[0] = 0; pops[1] = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      drive_rand();
      step();
    end
    drain();
    chk("fullrate_count_p1", 32'(pops[0]), 32'd16);
    chk("fullrate_count_p2", 32'(pops[1]), 32'd16);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      drive_rand();
      step();
    end
    drain();
    chk("final_empty_p1", 32'(q0.size()), 32'd0);
    chk("final_empty_p2", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
